// File: rtl/llc_set_lookup_pkg.sv
// Shared types and constants for the LLC set-lookup controller.
package llc_set_lookup_pkg;

  localparam int LLC_NUM_WAYS   = 16;
  localparam int LLC_SET_BITS   = 9;
  localparam int LLC_TAG_BITS   = 15;
  localparam int LLC_STATE_BITS = 3;
  localparam int LLC_WAY_BITS   = $clog2(LLC_NUM_WAYS);

  typedef logic [LLC_SET_BITS-1:0]   llc_set_t;
  typedef logic [LLC_TAG_BITS-1:0]   llc_tag_t;
  typedef logic [LLC_STATE_BITS-1:0] llc_state_t;
  typedef logic [LLC_WAY_BITS-1:0]   llc_way_t;

  // A line in this state holds no data; the reset sweep writes it everywhere.
  localparam llc_state_t LLC_INVALID = '0;

  typedef enum logic [2:0] {
    ST_SWEEP   = 3'd0,
    ST_IDLE    = 3'd1,
    ST_READ    = 3'd2,
    ST_RESOLVE = 3'd3,
    ST_RESP    = 3'd4
  } llc_fsm_t;

endpackage

// File: rtl/llc_way_select.sv
// Priority encoder over one set: lowest-index hit way and lowest-index empty way.
module llc_way_select
  import llc_set_lookup_pkg::*;
#(
  parameter int NUM_WAYS   = 16,
  parameter int TAG_BITS   = 15,
  parameter int STATE_BITS = 3,
  parameter int WAY_BITS   = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS*TAG_BITS-1:0]   tags,
  input  logic [NUM_WAYS*STATE_BITS-1:0] states,
  input  logic [TAG_BITS-1:0]            lookup_tag,
  output logic                           hit,
  output logic [WAY_BITS-1:0]            hit_way,
  output logic                           empty,
  output logic [WAY_BITS-1:0]            empty_way
);

  // Scan from the top down so the lowest matching index is the last one written.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    empty     = 1'b0;
    empty_way = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (states[i*STATE_BITS +: STATE_BITS] != STATE_BITS'(LLC_INVALID) &&
          tags[i*TAG_BITS +: TAG_BITS] == lookup_tag) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(i);
      end
      if (states[i*STATE_BITS +: STATE_BITS] == STATE_BITS'(LLC_INVALID)) begin
        empty     = 1'b1;
        empty_way = WAY_BITS'(i);
      end
    end
  end

endmodule

// File: rtl/llc_set_lookup.sv
// LLC request-side controller: post-reset invalidation sweep, then one
// tag lookup at a time with round-robin victim selection per set.
module llc_set_lookup
  import llc_set_lookup_pkg::*;
#(
  parameter int NUM_WAYS   = 16,
  parameter int SET_BITS   = 9,
  parameter int TAG_BITS   = 15,
  parameter int STATE_BITS = 3,
  parameter int WAY_BITS   = $clog2(NUM_WAYS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [SET_BITS-1:0]            req_set,
  input  logic [TAG_BITS-1:0]            req_tag,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic                           resp_hit,
  output logic                           resp_empty,
  output logic [WAY_BITS-1:0]            resp_way,
  output logic [STATE_BITS-1:0]          resp_state,
  output logic                           init_done,
  output logic                           rd_en,
  output logic [SET_BITS-1:0]            set_in,
  output logic [NUM_WAYS-1:0]            wr_rst_flush,
  output logic [STATE_BITS-1:0]          wr_data_state,
  output logic                           wr_data_dirty_bit,
  output logic                           wr_en_evict_way,
  output logic [WAY_BITS-1:0]            wr_data_evict_way,
  input  logic [NUM_WAYS*TAG_BITS-1:0]   rd_data_tag,
  input  logic [NUM_WAYS*STATE_BITS-1:0] rd_data_state,
  input  logic [WAY_BITS-1:0]            rd_data_evict_way
);

  llc_fsm_t                      state_q, state_d;
  // One extra bit: the top bit set means every set has been flushed.
  logic [SET_BITS:0]             cnt_q, cnt_d;
  logic                          req_ready_q, req_ready_d;
  logic                          rd_en_q, rd_en_d;
  logic [SET_BITS-1:0]           set_in_q, set_in_d;
  logic [NUM_WAYS-1:0]           flush_q, flush_d;
  logic                          init_done_q, init_done_d;
  logic                          resp_valid_q, resp_valid_d;
  logic                          resp_hit_q, resp_hit_d;
  logic                          resp_empty_q, resp_empty_d;
  logic [WAY_BITS-1:0]           resp_way_q, resp_way_d;
  logic [STATE_BITS-1:0]         resp_state_q, resp_state_d;

  logic [TAG_BITS-1:0]           lk_tag_q;
  logic [NUM_WAYS*TAG_BITS-1:0]  tag_q;
  logic [NUM_WAYS*STATE_BITS-1:0] st_q;
  logic [WAY_BITS-1:0]           evict_q;

  logic                          accept;
  logic                          hit, empty, victim;
  logic [WAY_BITS-1:0]           hit_way, empty_way, sel_way, evict_next;
  logic [STATE_BITS-1:0]         sel_state;

  // The memory is addressed in the accept cycle itself so its data lands in READ.
  assign accept = (state_q == ST_IDLE) && req_ready_q && req_valid;

  llc_way_select #(
    .NUM_WAYS  (NUM_WAYS),
    .TAG_BITS  (TAG_BITS),
    .STATE_BITS(STATE_BITS),
    .WAY_BITS  (WAY_BITS)
  ) u_way_select (
    .tags      (tag_q),
    .states    (st_q),
    .lookup_tag(lk_tag_q),
    .hit       (hit),
    .hit_way   (hit_way),
    .empty     (empty),
    .empty_way (empty_way)
  );

  // Pick the reported way and its state; the victim path advances the pointer.
  always_comb begin
    sel_way   = hit ? hit_way : (empty ? empty_way : evict_q);
    sel_state = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (sel_way == WAY_BITS'(i)) sel_state = st_q[i*STATE_BITS +: STATE_BITS];
    end
    evict_next = (evict_q == WAY_BITS'(NUM_WAYS - 1)) ? '0 : evict_q + 1'b1;
    victim     = (state_q == ST_RESOLVE) && !hit && !empty;
  end

  // Next-state and next-output logic for the lookup FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_ready_d  = 1'b0;
    rd_en_d      = 1'b0;
    set_in_d     = '0;
    flush_d      = '0;
    init_done_d  = init_done_q;
    resp_valid_d = 1'b0;
    resp_hit_d   = 1'b0;
    resp_empty_d = 1'b0;
    resp_way_d   = '0;
    resp_state_d = '0;
    case (state_q)
      ST_SWEEP: begin
        if (cnt_q[SET_BITS]) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
          req_ready_d = 1'b1;
        end else begin
          rd_en_d  = 1'b1;
          flush_d  = '1;
          set_in_d = cnt_q[SET_BITS-1:0];
          cnt_d    = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_READ;
          set_in_d = req_set;
        end else begin
          req_ready_d = 1'b1;
        end
      end
      ST_READ: begin
        state_d  = ST_RESOLVE;
        set_in_d = set_in_q;
      end
      ST_RESOLVE: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_hit_d   = hit;
        resp_empty_d = !hit && empty;
        resp_way_d   = sel_way;
        resp_state_d = sel_state;
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d     = ST_IDLE;
          req_ready_d = 1'b1;
        end else begin
          resp_valid_d = 1'b1;
          resp_hit_d   = resp_hit_q;
          resp_empty_d = resp_empty_q;
          resp_way_d   = resp_way_q;
          resp_state_d = resp_state_q;
        end
      end
      default: state_d = ST_SWEEP;
    endcase
  end

  // FSM state and registered outputs; reset aborts any sweep or lookup.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_SWEEP;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      rd_en_q      <= 1'b0;
      set_in_q     <= '0;
      flush_q      <= '0;
      init_done_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_empty_q <= 1'b0;
      resp_way_q   <= '0;
      resp_state_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      rd_en_q      <= rd_en_d;
      set_in_q     <= set_in_d;
      flush_q      <= flush_d;
      init_done_q  <= init_done_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_empty_q <= resp_empty_d;
      resp_way_q   <= resp_way_d;
      resp_state_q <= resp_state_d;
    end
  end

  // Lookup tag and the set read back from memory; qualified by FSM state, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) lk_tag_q <= req_tag;
    if (state_q == ST_READ) begin
      tag_q   <= rd_data_tag;
      st_q    <= rd_data_state;
      evict_q <= rd_data_evict_way;
    end
  end

  assign req_ready         = req_ready_q;
  assign resp_valid        = resp_valid_q;
  assign resp_hit          = resp_hit_q;
  assign resp_empty        = resp_empty_q;
  assign resp_way          = resp_way_q;
  assign resp_state        = resp_state_q;
  assign init_done         = init_done_q;
  assign rd_en             = rd_en_q | accept;
  assign set_in            = accept ? req_set : set_in_q;
  assign wr_rst_flush      = flush_q;
  assign wr_data_state     = STATE_BITS'(LLC_INVALID);
  assign wr_data_dirty_bit = 1'b0;
  assign wr_en_evict_way   = victim;
  assign wr_data_evict_way = victim ? evict_next : '0;

endmodule

// File: doc/llc_set_lookup.md
# llc_set_lookup

Request-side controller for the LLC local memory: it owns that memory's read/write-control port. It performs the post-reset invalidation sweep over every set, then serves tag lookups. For each lookup it reads a set, resolves hit, empty or victim way, and advances the per-set round-robin eviction pointer. It sits between the LLC request arbiter and the local memory.

## Interface
Parameters:
- NUM_WAYS, 16: ways per set; equals the memory's port count.
- SET_BITS, 9: set index width.
- TAG_BITS, 15: tag width.
- STATE_BITS, 3: state width; INVALID is encoded as 0.
- WAY_BITS, $clog2(NUM_WAYS): way index width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- req_valid  in  1  lookup request.
- req_ready  out  1  the block accepts the request this cycle.
- req_set  in  SET_BITS  set to look up.
- req_tag  in  TAG_BITS  tag to match.
- resp_valid  out  1  lookup result valid.
- resp_ready  in  1  consumer takes the result.
- resp_hit  out  1  a tag matched in a valid way.
- resp_empty  out  1  no hit, and an INVALID way exists.
- resp_way  out  WAY_BITS  hit way, else empty way, else victim way.
- resp_state  out  STATE_BITS  state of resp_way.
- init_done  out  1  the reset sweep is complete.
- rd_en  out  1  memory chip enable.
- set_in  out  SET_BITS  memory set address.
- wr_rst_flush  out  NUM_WAYS  per-way invalidate strobe.
- wr_data_state  out  STATE_BITS  write state; always INVALID.
- wr_data_dirty_bit  out  1  write dirty bit; always 0.
- wr_en_evict_way  out  1  evict-pointer write strobe.
- wr_data_evict_way  out  WAY_BITS  new evict pointer.
- rd_data_tag  in  NUM_WAYS x TAG_BITS  per-way tags.
- rd_data_state  in  NUM_WAYS x STATE_BITS  per-way states.
- rd_data_evict_way  in  WAY_BITS  evict pointer of the addressed set.

## Operation
The FSM has five states: SWEEP, IDLE, READ, RESOLVE, RESP.

SWEEP:
- Entered on reset.
- Each cycle asserts rd_en=1 and wr_rst_flush=all-ones, with set_in equal to the sweep counter.
- The counter runs from 0 to 2^SET_BITS-1, one set per cycle.
- When the last set is written, init_done is set and the FSM goes to IDLE.

IDLE:
- req_ready=1.
- On req_valid, latch req_set and req_tag, drive rd_en=1 and set_in=req_set, then go to READ.

READ:
- Memory data is valid this cycle (1-cycle SRAM latency).
- Register per-way tags and states plus the evict pointer, then go to RESOLVE.
- set_in holds the latched set throughout READ and RESOLVE.

RESOLVE computes the result from the registered data:
- Hit: the lowest-index way with state != INVALID and a matching tag; resp_hit=1.
- Otherwise empty: the lowest-index INVALID way; resp_empty=1.
- Otherwise victim: resp_way equals the registered evict pointer.
- Victim case only: pulse wr_en_evict_way for one cycle with wr_data_evict_way = (victim + 1) mod NUM_WAYS. The increment wraps NUM_WAYS-1 to 0.
- Always go to RESP.

RESP:
- resp_valid=1; the resp_* outputs are registered and held stable.
- When resp_ready=1, go to IDLE.

General rules:
- Outputs not listed for a state are 0. wr_data_state and wr_data_dirty_bit are constant 0.
- No new request is accepted until the response completes; one lookup is in flight at a time.

## Timing
- Reset values: all outputs 0. This includes req_ready, resp_*, init_done, rd_en, set_in, wr_rst_flush and wr_en_evict_way.
- The sweep takes exactly 2^SET_BITS cycles after reset deassertion; init_done rises the cycle after the last sweep write.
- Request accept to resp_valid is 3 cycles if resp_ready is already high: IDLE→READ→RESOLVE→RESP.
- Back-to-back throughput is one lookup per 4 cycles.
- resp_valid stays high with stable data while resp_ready is low.
- req_valid during SWEEP is ignored (req_ready=0).
- Reset asserted mid-lookup or mid-sweep aborts the operation, returns the FSM to SWEEP and clears the counter. No evict-pointer write is issued after reset.
- A simultaneous valid state and matching tag in two ways is illegal; the lowest index is reported.
- The evict-pointer write and its read of the same set never overlap, because the pointer is read in READ and written in RESOLVE.

## Structure
- Shared package holds:
  - the llc_set_t, llc_tag_t, llc_state_t and llc_way_t typedefs;
  - the INVALID state constant;
  - the FSM state enum.
- One sub-module, llc_way_select: a combinational priority encoder that outputs the hit way, the empty way and the hit/empty flags. It is parameterised on NUM_WAYS.

## Test plan
- Reset release with SET_BITS=9:
  - wr_rst_flush=all-ones for exactly 512 cycles, set_in stepping 0..511;
  - init_done rises on the cycle after set 511;
  - req_ready stays 0 throughout.
- Hit: memory model has way 5 valid with tag 0x1A3 in set 7; request set 7, tag 0x1A3 → resp_hit=1, resp_way=5, 3 cycles after accept, no evict write.
- Empty: all ways valid except ways 3 and 9, no tag match → resp_empty=1, resp_way=3, no evict write.
- Victim: all 16 ways valid, no match, pointer=15 → resp_way=15, wr_en_evict_way pulses once with data 0 (wrap), set_in=requested set.
- Backpressure: hold resp_ready=0 for 10 cycles → resp_valid and resp_way stable, req_ready=0, then release → IDLE.
- Reset asserted during RESOLVE: all outputs 0 immediately, no evict write, and the sweep restarts from set 0.
